// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared sizes and priority encoding for the write-back arbiter
//   RF_WORD_LENGTH : data width of one register
//   RF_REG_NUM     : number of architectural registers (x0 hard-wired zero)
//   RF_IDX_W       : register index width
//   prio_t         : which requester wins the next contended cycle
package rf_wb_arbiter_pkg;
  localparam int RF_WORD_LENGTH = 32;
  localparam int RF_REG_NUM     = 32;
  localparam int RF_IDX_W       = $clog2(RF_REG_NUM);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - issue, write-back and RF-write bundle of the write-back arbiter
//   iss_*  : IDU issue handshake (valid/rd in, ready out)
//   a_*    : EXU write-back request (valid/rd/data in, ready out)
//   b_*    : LSU write-back request (valid/rd/data in, ready out)
//   rf_we, rf_wdata : registered RF write port
//   busy   : pending-destination scoreboard
//   master : requester/IDU side, slave : arbiter side
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int WORD_LENGTH = RF_WORD_LENGTH,
  parameter int REG_NUM     = RF_REG_NUM,
  parameter int IDX_W       = RF_IDX_W
) ();
  logic                           iss_valid;
  logic [IDX_W-1:0]               iss_rd;
  logic                           iss_ready;
  logic                           a_valid;
  logic [IDX_W-1:0]               a_rd;
  logic [WORD_LENGTH-1:0]         a_data;
  logic                           a_ready;
  logic                           b_valid;
  logic [IDX_W-1:0]               b_rd;
  logic [WORD_LENGTH-1:0]         b_data;
  logic                           b_ready;
  logic [REG_NUM-1:0]             rf_we;
  logic [REG_NUM*WORD_LENGTH-1:0] rf_wdata;
  logic [REG_NUM-1:0]             busy;

  modport master (
    output iss_valid, iss_rd, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  iss_ready, a_ready, b_ready, rf_we, rf_wdata, busy
  );

  modport slave (
    input  iss_valid, iss_rd, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output iss_ready, a_ready, b_ready, rf_we, rf_wdata, busy
  );
endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rtl/rf_wb_arbiter_rr_arb2.sv - two-way round-robin arbiter, one grant per cycle
//   clk, rst         : clock, synchronous active-low reset
//   a_valid, b_valid : requests
//   a_gnt, b_gnt     : combinational grants
module rf_wb_arbiter_rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_gnt,
  output logic b_gnt
);
  prio_t prio;

  // prio only matters when both request; a lone requester always wins.
  assign a_gnt = a_valid && (!b_valid || prio == PRIO_A);
  assign b_gnt = b_valid && (!a_valid || prio == PRIO_B);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio <= PRIO_A;
    end else if (a_gnt) begin
      prio <= PRIO_B;
    end else if (b_gnt) begin
      prio <= PRIO_A;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - write-back arbiter: registers the winning write and tracks pending rds
//   clk : clock, rst : synchronous active-low reset
//   bus : rf_wb_arbiter_if.slave (issue, A/B write-back, RF write port, busy)
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int WORD_LENGTH = RF_WORD_LENGTH,
  parameter int REG_NUM     = RF_REG_NUM,
  parameter int IDX_W       = RF_IDX_W
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  logic                           a_gnt;
  logic                           b_gnt;
  logic                           win;
  logic [IDX_W-1:0]               win_rd;
  logic [WORD_LENGTH-1:0]         win_data;
  logic [REG_NUM-1:0]             win_dec;
  logic [REG_NUM-1:0]             iss_dec;
  logic [REG_NUM-1:0]             set_mask;
  logic                           iss_rdy;
  logic [REG_NUM-1:0]             rf_we_q;
  logic [REG_NUM*WORD_LENGTH-1:0] rf_wdata_q;
  logic [REG_NUM-1:0]             busy_q;

  rf_wb_arbiter_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .a_valid (bus.a_valid),
    .b_valid (bus.b_valid),
    .a_gnt   (a_gnt),
    .b_gnt   (b_gnt)
  );

  assign iss_rdy = ~busy_q[bus.iss_rd];

  always_comb begin
    win      = a_gnt | b_gnt;
    win_rd   = a_gnt ? bus.a_rd : bus.b_rd;
    win_data = a_gnt ? bus.a_data : bus.b_data;
    win_dec  = '0;
    win_dec[win_rd] = 1'b1;
    iss_dec  = '0;
    iss_dec[bus.iss_rd] = 1'b1;
    set_mask = (bus.iss_valid && iss_rdy && bus.iss_rd != '0) ? iss_dec : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      // rd==0 is still accepted upstream but never reaches the RF.
      rf_we_q <= (win && win_rd != '0) ? win_dec : '0;
      if (win) begin
        rf_wdata_q <= {REG_NUM{win_data}};
      end
      // Clear on the edge the RF captures the write; a same-edge set wins.
      // Bit 0 is forced low so x0 can never stall issue.
      busy_q <= ((busy_q & ~rf_we_q) | set_mask) & {{(REG_NUM-1){1'b1}}, 1'b0};
    end
  end

  assign bus.a_ready   = a_gnt;
  assign bus.b_ready   = b_gnt;
  assign bus.iss_ready = iss_rdy;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = busy_q;
endmodule
